// File: rtl/vram_arbiter.sv
// Two-requester VRAM port arbiter: video text fetch has priority, and a
// starvation counter forces a CPU slot. Optional statistics under VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 8,
    parameter int MEM_LATENCY    = 2,
    parameter int CPU_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_stall_cycles,
    output logic [7:0]        vid_stall_max
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_MAX);

    state_t     state_r;
    logic       owner_cpu_r;
    logic [2:0] lat_cnt_r;
    logic [3:0] starve_cnt_r;
    logic       grant_cpu_s;
    logic       grant_vid_s;

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_vid_s = 1'b0;
        if (cpu_req && (!vid_req || (starve_cnt_r >= STARVE_LIM))) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_vid_s = vid_req;
        end
    end

    // Access sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_cpu_r  <= 1'b0;
            lat_cnt_r    <= 3'd0;
            starve_cnt_r <= 4'd0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            vid_data     <= '0;
            vid_valid    <= 1'b0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            vid_valid <= 1'b0;
            cpu_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_cpu_s) begin
                        owner_cpu_r  <= 1'b1;
                        mem_addr     <= cpu_addr;
                        mem_we       <= cpu_we;
                        mem_wdata    <= cpu_wdata;
                        mem_en       <= 1'b1;
                        starve_cnt_r <= 4'd0;
                        state_r      <= ISSUE;
                    end else if (grant_vid_s) begin
                        owner_cpu_r  <= 1'b0;
                        mem_addr     <= vid_addr;
                        mem_we       <= 1'b0;
                        mem_wdata    <= '0;
                        mem_en       <= 1'b1;
                        // Only video wins that leave the CPU waiting count toward starvation.
                        if (cpu_req) begin
                            starve_cnt_r <= (starve_cnt_r == 4'd15) ? 4'd15 : starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_r <= 4'd0;
                        end
                        state_r      <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    lat_cnt_r <= LAT_LOAD;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_r == 3'd0) begin
                        if (owner_cpu_r) begin
                            if (!mem_we) begin
                                cpu_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= cpu_rdata;
                            end
                        end else begin
                            vid_data <= mem_rdata;
                        end
                        state_r <= DONE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    if (owner_cpu_r) begin
                        cpu_ready <= 1'b1;
                    end else begin
                        vid_valid <= 1'b1;
                    end
                    mem_we  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic       vid_req_d_r;
    logic       vid_busy_r;
    logic [7:0] vid_wait_r;

    // CPU stall cycle counter, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_stall_cycles <= 16'd0;
        end else if (cpu_req && !cpu_ready && (cpu_stall_cycles != 16'hFFFF)) begin
            cpu_stall_cycles <= cpu_stall_cycles + 16'd1;
        end else begin
            cpu_stall_cycles <= cpu_stall_cycles;
        end
    end

    // Worst-case video request-to-valid time, measured from the request rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_req_d_r   <= 1'b0;
            vid_busy_r    <= 1'b0;
            vid_wait_r    <= 8'd0;
            vid_stall_max <= 8'd0;
        end else begin
            vid_req_d_r <= vid_req;
            if (vid_busy_r && vid_valid) begin
                vid_busy_r <= 1'b0;
                if (vid_wait_r > vid_stall_max) begin
                    vid_stall_max <= vid_wait_r;
                end else begin
                    vid_stall_max <= vid_stall_max;
                end
            end else if (vid_req && !vid_req_d_r) begin
                vid_busy_r <= 1'b1;
                vid_wait_r <= 8'd1;
            end else if (vid_busy_r && (vid_wait_r != 8'hFF)) begin
                vid_wait_r <= vid_wait_r + 8'd1;
            end else begin
                vid_wait_r <= vid_wait_r;
            end
        end
    end
`endif

endmodule
